// File: rtl/pic_ctrl_fsm.sv
// Instruction-cycle controller for the 8-bit core.
// Sequences fetch, decode, execute and writeback, and owns the PC.
module pic_ctrl_fsm #(
  parameter int              PC_W      = 8,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             pmem_ack,
  input  logic [3:0]       inst,
  input  logic             d,
  output logic [PC_W-1:0]  pc,
  output logic             pmem_req,
  output logic             ir_load,
  output logic             f_rd,
  output logic [3:0]       alu_op,
  output logic             w_we,
  output logic             f_we,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_NOP  = 4'd8;
  localparam logic [3:0] OP_CLR  = 4'd9;
  localparam logic [3:0] OP_SWAP = 4'd11;

  state_t     state;
  logic [3:0] inst_q;
  logic       d_q;
  logic [3:0] inst_n;
  logic       reads_f;
  logic       commits;
  logic       fetch_go;

  // Fold unsupported decoder codes onto NOP.
  always_comb begin
    inst_n = OP_NOP;
    case (inst)
      OP_ADD,
      OP_AND,
      OP_CLR,
      OP_SWAP: inst_n = inst;
      default: inst_n = OP_NOP;
    endcase
  end

  // Operand read is needed for two-operand and in-place ops only.
  always_comb begin
    reads_f = 1'b0;
    case (inst_n)
      OP_ADD,
      OP_AND,
      OP_SWAP: reads_f = 1'b1;
      default: reads_f = 1'b0;
    endcase
  end

  assign commits  = (inst_q != OP_NOP);

  // Request is held in reset so no fetch starts before release.
  assign pmem_req = rst_n
                  & (state == FETCH)
                  & ~stall_i;
  assign fetch_go = pmem_req & pmem_ack;
  assign ir_load  = fetch_go;
  assign busy     = (state != FETCH)
                  | pmem_req;

  // Sequencer with registered per-phase strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      pc      <= RESET_VEC;
      retired <= '0;
      inst_q  <= OP_NOP;
      d_q     <= 1'b0;
      alu_op  <= 4'd0;
      f_rd    <= 1'b0;
      w_we    <= 1'b0;
      f_we    <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (fetch_go)
            state <= DECODE;
        end
        DECODE: begin
          inst_q <= inst_n;
          d_q    <= d;
          alu_op <= inst_n;
          f_rd   <= reads_f;
          state  <= EXEC;
        end
        EXEC: begin
          f_rd  <= 1'b0;
          w_we  <= commits & ~d_q;
          f_we  <= commits & d_q;
          state <= WB;
        end
        WB: begin
          w_we    <= 1'b0;
          f_we    <= 1'b0;
          alu_op  <= 4'd0;
          pc      <= pc + PC_W'(1);
          retired <= retired + CNT_W'(1);
          state   <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_pic_ctrl_fsm.sv
// Bench for pic_ctrl_fsm: directed steps then random cycles
// against a per-instruction phase model.
module tb_pic_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b1;
  logic        pmem_ack = 1'b0;
  logic [3:0]  inst = 4'd0;
  logic        d = 1'b0;

  logic [7:0]  pc;
  logic        pmem_req, ir_load, f_rd, w_we, f_we, busy;
  logic [3:0]  alu_op;
  logic [15:0] retired;

  logic [7:0]  pc_b;
  logic        pmem_req_b, ir_load_b, f_rd_b, w_we_b, f_we_b, busy_b;
  logic [3:0]  alu_op_b;
  logic [3:0]  retired_b;

  int vectors = 0;
  int errors  = 0;

  // model: ph<0 fetching, else cycles since the ack (1..3)
  int          ph = -1;
  logic [3:0]  code = 4'd8;
  logic        dq = 1'b0;
  logic [7:0]  mpc = 8'd0;
  logic [15:0] mret = 16'd0;

  always #5 clk = ~clk;

  pic_ctrl_fsm #(.PC_W(8), .RESET_VEC(8'h00), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
    .pmem_ack(pmem_ack), .inst(inst), .d(d),
    .pc(pc), .pmem_req(pmem_req), .ir_load(ir_load),
    .f_rd(f_rd), .alu_op(alu_op), .w_we(w_we),
    .f_we(f_we), .busy(busy), .retired(retired)
  );

  pic_ctrl_fsm #(.PC_W(8), .RESET_VEC(8'hFF), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
    .pmem_ack(pmem_ack), .inst(inst), .d(d),
    .pc(pc_b), .pmem_req(pmem_req_b), .ir_load(ir_load_b),
    .f_rd(f_rd_b), .alu_op(alu_op_b), .w_we(w_we_b),
    .f_we(f_we_b), .busy(busy_b), .retired(retired_b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] norm(input logic [3:0] c);
    if (c == 4'd2 || c == 4'd4 || c == 4'd9 || c == 4'd11)
      return c;
    return 4'd8;
  endfunction

  task automatic check_all(input logic in_rst);
    logic       e_req, e_ld, e_frd, e_wwe, e_fwe, e_busy;
    logic [3:0] e_op;
    e_req  = !in_rst && ph < 0 && !stall_i;
    e_ld   = e_req && pmem_ack;
    e_busy = ph >= 0 || e_req;
    e_op   = (ph >= 2) ? code : 4'd0;
    e_frd  = ph == 2 && (code == 4'd2 || code == 4'd4 || code == 4'd11);
    e_wwe  = ph == 3 && code != 4'd8 && !dq;
    e_fwe  = ph == 3 && code != 4'd8 && dq;
    chk("pmem_req", 32'(pmem_req), 32'(e_req));
    chk("ir_load",  32'(ir_load),  32'(e_ld));
    chk("busy",     32'(busy),     32'(e_busy));
    chk("alu_op",   32'(alu_op),   32'(e_op));
    chk("f_rd",     32'(f_rd),     32'(e_frd));
    chk("w_we",     32'(w_we),     32'(e_wwe));
    chk("f_we",     32'(f_we),     32'(e_fwe));
    chk("pc",       32'(pc),       32'(mpc));
    chk("retired",  32'(retired),  32'(mret));
    chk("pc_wrap",  32'(pc_b),     32'(8'(mpc + 8'hFF)));
    chk("ret_wrap", 32'(retired_b), 32'(mret[3:0]));
    chk("busy_b",   32'(busy_b),   32'(e_busy));
    chk("wr_excl",  32'(w_we & f_we), 32'(0));
  endtask

  task automatic step(input logic s, input logic a,
                      input logic [3:0] i, input logic dd);
    @(negedge clk);
    stall_i = s; pmem_ack = a; inst = i; d = dd;
    #1;
    check_all(1'b0);
    if (ph < 0) begin
      if (!s && a) ph = 1;
    end else if (ph == 1) begin
      code = norm(i); dq = dd; ph = 2;
    end else if (ph == 2) begin
      ph = 3;
    end else begin
      mpc = mpc + 8'd1; mret = mret + 16'd1; ph = -1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; stall_i = 1'b0; pmem_ack = 1'b1;
    #1;
    ph = -1; mpc = 8'd0; mret = 16'd0; code = 4'd8; dq = 1'b0;
    check_all(1'b1);
    @(negedge clk);
    stall_i = 1'b1; pmem_ack = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic instr(input logic [3:0] i, input logic dd);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, i, dd);
  endtask

  initial begin
    do_reset();
    // ADD to W, then ADD to file repeated
    instr(4'd2, 1'b0);
    for (int k = 0; k < 3; k++) instr(4'd2, 1'b1);
    // CLR to file, NOP, unsupported, SWAP, AND
    instr(4'd9, 1'b1);
    instr(4'd8, 1'b0);
    instr(4'd5, 1'b1);
    instr(4'd11, 1'b0);
    instr(4'd4, 1'b1);
    // stall two cycles, then ack three cycles after request
    step(1'b1, 1'b1, 4'd2, 1'b0);
    step(1'b1, 1'b1, 4'd2, 1'b0);
    step(1'b0, 1'b0, 4'd2, 1'b0);
    step(1'b0, 1'b0, 4'd2, 1'b0);
    step(1'b0, 1'b0, 4'd2, 1'b0);
    step(1'b0, 1'b1, 4'd2, 1'b0);
    step(1'b1, 1'b0, 4'd2, 1'b0);
    step(1'b1, 1'b0, 4'd2, 1'b0);
    step(1'b1, 1'b0, 4'd2, 1'b0);
    // reset during EXEC of an ADD to W
    step(1'b0, 1'b1, 4'd2, 1'b0);
    step(1'b0, 1'b1, 4'd2, 1'b0);
    do_reset();
    instr(4'd2, 1'b0);
    // random traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] ri;
      case ($urandom_range(0, 5))
        0: ri = 4'd2;
        1: ri = 4'd4;
        2: ri = 4'd9;
        3: ri = 4'd11;
        4: ri = 4'd8;
        default: ri = 4'($urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 299) == 0)
        do_reset();
      else
        step($urandom_range(0, 3) == 0,
             $urandom_range(0, 1) == 1,
             ri, 1'($urandom_range(0, 1)));
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
